zynq_dpr_scheduler: RTL and testbench
=====================================

# zynq_dpr_scheduler

Sequences dynamic partial reconfiguration (DPR) for a set of reconfigurable regions, each guarded by its own SEU healer that raises a SEFI heal request. Round-robin arbitration between pending requests. One region is handed to the single PCAP/ICAP reconfiguration engine at a time, with retry on error and a post-reconfiguration veto hold. Sits between the per-region healers and the DPR engine, and drives the shared veto line to downstream consumers.

## Interface
- `N_REGIONS`, 4: number of reconfigurable regions/requesters (2..16).
- `TIMEOUT_CYCLES`, 65535: watchdog limit for one DPR attempt, in clock cycles.
- `MAX_RETRY`, 2: re-attempts after the first failed attempt before a region is marked failed.
- `VETO_HOLD`, 16: cycles `veto_pulse` stays high after an attempt sequence ends (≥1).
- `clk_500mhz`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sefi_req`  in  N_REGIONS  level heal request per region; held by requester until acked.
- `sefi_ack`  out  N_REGIONS  one-cycle one-hot pulse: request accepted.
- `dpr_start`  out  1  one-cycle pulse: begin reconfiguration of `dpr_region`.
- `dpr_region`  out  $clog2(N_REGIONS)  region index; stable from `dpr_start` until the attempt ends.
- `dpr_done`  in  1  one-cycle pulse: reconfiguration succeeded.
- `dpr_error`  in  1  one-cycle pulse: reconfiguration failed.
- `veto_pulse`  out  1  high while any region is in reconfiguration or hold.
- `region_fail`  out  N_REGIONS  sticky: region exhausted retries; cleared only by `rst`.
- `heal_count`  out  16  successful heals, saturating at 0xFFFF.

## Operation
- States: IDLE, RUN, COOLDOWN.
- **IDLE**
  - Eligible set = `sefi_req & ~region_fail`.
  - If the set is non-empty at cycle t, pick round-robin, starting from the index after the last grant.
  - At t+1: `sefi_ack[idx]`=1, `dpr_start`=1, `dpr_region`=idx, `veto_pulse`=1, retry counter=0. Enter RUN.
- **RUN** (waits for `dpr_done`/`dpr_error`)
  - On `dpr_done`: `heal_count`+1 (saturating), enter COOLDOWN.
  - On `dpr_error`, or watchdog expiry, with retries < MAX_RETRY: increment retry counter and pulse `dpr_start` again next cycle (same region). No new `sefi_ack`.
  - On `dpr_error` or watchdog expiry with retries == MAX_RETRY: set `region_fail[idx]`, enter COOLDOWN.
  - `dpr_done` and `dpr_error` in the same cycle: treated as error.
  - `dpr_done`/`dpr_error` outside RUN: ignored.
- **COOLDOWN**
  - `veto_pulse` stays high for exactly VETO_HOLD cycles, then IDLE with `veto_pulse`=0.
  - Requests arriving meanwhile stay pending; they are not acked until IDLE.
- Round-robin pointer updates only on grant.
- Requests from failed regions are never acked.
- If every region is failed, the block idles forever.

## Timing
- Reset values: `sefi_ack`=0, `dpr_start`=0, `dpr_region`=0, `veto_pulse`=0, `region_fail`=0, `heal_count`=0, state IDLE.
- After reset the round-robin pointer equals N_REGIONS-1, so region 0 wins first.
- Request-to-start latency: 1 cycle from the IDLE sample.
- Retry-restart latency: 1 cycle after the error or expiry cycle.
- Watchdog: counter clears on each `dpr_start` and increments every RUN cycle. Expiry occurs when it reaches TIMEOUT_CYCLES-1 without done or error.
- Minimum spacing between two grants: VETO_HOLD+2 cycles plus the engine's response time.
- `rst` mid-RUN aborts immediately. No `dpr_start` is issued in the reset cycle or the cycle after it.
- All outputs are registered.

## Configuration
- `DPR_SCHED_WATCHDOG_EN` defined: watchdog counter present, and expiry behaves as `dpr_error`.
- Undefined: no counter logic is built and TIMEOUT_CYCLES is ignored. RUN waits indefinitely for `dpr_done`/`dpr_error`.

## Structure
- Shared package `zynq_heal_pkg`:
  - state enum `dpr_sched_state_t` (IDLE/RUN/COOLDOWN);
  - `HEAL_COUNT_W`=16;
  - `HEAL_COUNT_MAX`=16'hFFFF.
- Sub-module `zynq_rr_arbiter`: parameterized N-way round-robin pick.
  - Inputs: request vector, last-grant pointer.
  - Outputs: one-hot grant, index, valid.
  - Purely combinational; the pointer register stays in the parent.

## Test plan
- Single request: `sefi_req`=4'b0100 at t → `sefi_ack`=4'b0100 and `dpr_start` at t+1, `dpr_region`=2. Then `dpr_done` → `heal_count`=1, `veto_pulse` falls exactly 16 cycles later.
- Fairness: `sefi_req`=4'b1111 held and re-asserted after each ack, `dpr_done` 10 cycles after each start → grant order 0,1,2,3,0.
- Retry exhaustion: `dpr_error` after every start on region 1 → 3 `dpr_start` pulses, then `region_fail`=4'b0010, `heal_count`=0, and later region-1 requests are never acked.
- Watchdog (macro on, TIMEOUT_CYCLES=100): no response → `dpr_start` re-pulses at 100-cycle spacing, then `region_fail` set. With the macro off, the block stays in RUN for 10000 cycles.
- Simultaneous `dpr_done`+`dpr_error` → counted as a retry, `heal_count` unchanged. `rst` during RUN → all outputs 0 next cycle, and a new request restarts from region 0.
- Saturation: preload via 65535 successful heals (or force) → a further `dpr_done` leaves `heal_count`=0xFFFF.

Source files
------------

// File: rtl/zynq_heal_pkg.sv
// Shared types and constants for the SEU heal / DPR scheduling blocks.
package zynq_heal_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    COOLDOWN = 2'd2
  } dpr_sched_state_t;

  localparam int HEAL_COUNT_W = 16;
  localparam logic [HEAL_COUNT_W-1:0] HEAL_COUNT_MAX = 16'hFFFF;

  // Increment that sticks at the top value instead of wrapping.
  function automatic logic [HEAL_COUNT_W-1:0] heal_sat_inc(input logic [HEAL_COUNT_W-1:0] v);
    return (v == HEAL_COUNT_MAX) ? v : v + HEAL_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/zynq_rr_arbiter.sv
// Combinational N-way round-robin pick. Search starts at the index after
// last_ptr and wraps; the pointer register itself lives in the parent.
module zynq_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // First requester found walking forward from last_ptr+1 wins.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(last_ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/zynq_dpr_scheduler.sv
// DPR scheduler: arbitrates SEFI heal requests from the region healers,
// hands one region at a time to the reconfiguration engine, retries on
// error and holds the shared veto line for a cooldown after each sequence.
// Optional watchdog per attempt: define DPR_SCHED_WATCHDOG_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no region in flight; pick next eligible request round-robin
//   RUN      | engine busy on dpr_region; wait for done / error / expiry
//   COOLDOWN | attempt sequence over; veto held for VETO_HOLD cycles
module zynq_dpr_scheduler
  import zynq_heal_pkg::*;
#(
  parameter int unsigned N_REGIONS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned VETO_HOLD      = 16,
  localparam int unsigned IDX_W = $clog2(N_REGIONS)
) (
  input  logic                    clk_500mhz,
  input  logic                    rst,
  input  logic [N_REGIONS-1:0]    sefi_req,
  output logic [N_REGIONS-1:0]    sefi_ack,
  output logic                    dpr_start,
  output logic [IDX_W-1:0]        dpr_region,
  input  logic                    dpr_done,
  input  logic                    dpr_error,
  output logic                    veto_pulse,
  output logic [N_REGIONS-1:0]    region_fail,
  output logic [HEAL_COUNT_W-1:0] heal_count
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int unsigned HOLD_W  = $clog2(VETO_HOLD + 1);

  dpr_sched_state_t state_q, state_d;
  logic [N_REGIONS-1:0]    ack_q, ack_d;
  logic                    start_q, start_d;
  logic [IDX_W-1:0]        region_q, region_d;
  logic                    veto_q, veto_d;
  logic [N_REGIONS-1:0]    fail_q, fail_d;
  logic [HEAL_COUNT_W-1:0] heal_count_q, heal_count_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;

  logic [N_REGIONS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 wd_expire;

  zynq_rr_arbiter #(.N(N_REGIONS)) u_arb (
    .req      (sefi_req & ~fail_q),
    .last_ptr (ptr_q),
    .grant    (grant),
    .index    (grant_idx),
    .valid    (grant_valid)
  );

`ifdef DPR_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  assign wd_expire = (state_q == RUN) && (wd_q == '0);

  // Down-counter reloaded on every start; terminal count means the
  // attempt has run TIMEOUT_CYCLES cycles without a response.
  always_comb begin
    wd_d = wd_q;
    if (start_d) begin
      wd_d = WD_W'(TIMEOUT_CYCLES - 1);
    end else if (state_q == RUN && wd_q != '0) begin
      wd_d = wd_q - WD_W'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge clk_500mhz) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    start_d      = 1'b0;
    region_d     = region_q;
    veto_d       = veto_q;
    fail_d       = fail_q;
    heal_count_d = heal_count_q;
    ptr_d        = ptr_q;
    retry_d      = retry_q;
    hold_d       = hold_q;
    case (state_q)
      IDLE: begin
        veto_d = 1'b0;
        if (grant_valid) begin
          ack_d    = grant;
          start_d  = 1'b1;
          region_d = grant_idx;
          veto_d   = 1'b1;
          ptr_d    = grant_idx;
          retry_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Error beats done when both arrive; a real done beats expiry.
        if (dpr_error || (wd_expire && !dpr_done)) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            start_d = 1'b1;
          end else begin
            fail_d[region_q] = 1'b1;
            hold_d           = HOLD_W'(VETO_HOLD - 1);
            state_d          = COOLDOWN;
          end
        end else if (dpr_done) begin
          heal_count_d = heal_sat_inc(heal_count_q);
          hold_d       = HOLD_W'(VETO_HOLD - 1);
          state_d      = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (hold_q == '0) begin
          veto_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        veto_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; pointer resets so region 0 wins first.
  always_ff @(posedge clk_500mhz) begin
    if (rst) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      start_q      <= 1'b0;
      region_q     <= '0;
      veto_q       <= 1'b0;
      fail_q       <= '0;
      heal_count_q <= '0;
      ptr_q        <= IDX_W'(N_REGIONS - 1);
      retry_q      <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      start_q      <= start_d;
      region_q     <= region_d;
      veto_q       <= veto_d;
      fail_q       <= fail_d;
      heal_count_q <= heal_count_d;
      ptr_q        <= ptr_d;
      retry_q      <= retry_d;
      hold_q       <= hold_d;
    end
  end

  assign sefi_ack    = ack_q;
  assign dpr_start   = start_q;
  assign dpr_region  = region_q;
  assign veto_pulse  = veto_q;
  assign region_fail = fail_q;
  assign heal_count  = heal_count_q;

endmodule

// File: tb/tb_zynq_dpr_scheduler.sv
// Directed bench for zynq_dpr_scheduler: a vector table for the basic
// request/heal flow plus hand sequences for cooldown length, fairness,
// retry exhaustion, no-response, done+error, mid-RUN reset, saturation.
module tb_zynq_dpr_scheduler;

  logic        clk_500mhz = 1'b0;
  logic        rst;
  logic [3:0]  sefi_req;
  logic [3:0]  sefi_ack;
  logic        dpr_start;
  logic [1:0]  dpr_region;
  logic        dpr_done;
  logic        dpr_error;
  logic        veto_pulse;
  logic [3:0]  region_fail;
  logic [15:0] heal_count;

  int errors = 0;
  int checks = 0;

  always #1 clk_500mhz = ~clk_500mhz;

  zynq_dpr_scheduler #(
    .N_REGIONS(4), .TIMEOUT_CYCLES(100), .MAX_RETRY(2), .VETO_HOLD(16)
  ) dut (
    .clk_500mhz  (clk_500mhz),
    .rst         (rst),
    .sefi_req    (sefi_req),
    .sefi_ack    (sefi_ack),
    .dpr_start   (dpr_start),
    .dpr_region  (dpr_region),
    .dpr_done    (dpr_done),
    .dpr_error   (dpr_error),
    .veto_pulse  (veto_pulse),
    .region_fail (region_fail),
    .heal_count  (heal_count)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        done;
    logic        err;
    logic [3:0]  ack;
    logic        start;
    logic [1:0]  region;
    logic        veto;
    logic [3:0]  fail;
    logic [15:0] heal;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are applied at a falling edge and outputs read at the next one.
  task automatic step(input logic [3:0] req, input logic done, input logic err, input logic r);
    sefi_req  = req;
    dpr_done  = done;
    dpr_error = err;
    rst       = r;
    @(negedge clk_500mhz);
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_start(input logic [3:0] req, input string name);
    int n;
    n = 0;
    do begin
      step(req, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!dpr_start && n < 200);
    if (!dpr_start) chk({name, "_start_timeout"}, 32'(dpr_start), 32'd1);
  endtask

  task automatic wait_idle(input logic [3:0] req, input string name);
    int n;
    n = 0;
    while (veto_pulse && n < 200) begin
      step(req, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (veto_pulse) chk({name, "_idle_timeout"}, 32'(veto_pulse), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, starts, acks, last, cyc, lows;
    logic pend;
    logic [3:0] exp_ack;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    sefi_req = '0; dpr_done = 1'b0; dpr_error = 1'b0; rst = 1'b1;
    @(negedge clk_500mhz);
    do_reset();

    // rst, req, done, err | ack, start, region, veto, fail, heal
    vecs[0] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 16'd0};
    vecs[1] = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0000, 16'd0};
    vecs[2] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000, 16'd0};
    vecs[3] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000, 16'd1};
    vecs[4] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000, 16'd1};
    vecs[5] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000, 16'd1};

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].req, vecs[i].done, vecs[i].err, vecs[i].rst);
      chk($sformatf("vec%0d_ack", i),    32'(sefi_ack),    32'(vecs[i].ack));
      chk($sformatf("vec%0d_start", i),  32'(dpr_start),   32'(vecs[i].start));
      chk($sformatf("vec%0d_region", i), 32'(dpr_region),  32'(vecs[i].region));
      chk($sformatf("vec%0d_veto", i),   32'(veto_pulse),  32'(vecs[i].veto));
      chk($sformatf("vec%0d_fail", i),   32'(region_fail), 32'(vecs[i].fail));
      chk($sformatf("vec%0d_heal", i),   32'(heal_count),  32'(vecs[i].heal));
    end

    // Veto low exactly 16 edges after the done cycle (vec3); vec4/vec5 were two.
    n = 2;
    for (int i = 0; i < 40; i++) begin
      step(4'b0001, 1'b0, 1'b0, 1'b0);
      n++;
      if (!veto_pulse) break;
    end
    chk("veto_hold_len", 32'(n), 32'd16);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("pending_ack", 32'(sefi_ack), 32'b0001);
    chk("pending_start", 32'(dpr_start), 32'd1);
    chk("pending_region", 32'(dpr_region), 32'd0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("pending_heal", 32'(heal_count), 32'd2);
    wait_idle(4'b0000, "pending");

    // Fairness with all four requesting, done 10 cycles after each start.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      wait_start(4'b1111, $sformatf("fair%0d", g));
      exp_ack = 4'b0001 << order[g];
      chk($sformatf("fair%0d_region", g), 32'(dpr_region), 32'(order[g]));
      chk($sformatf("fair%0d_ack", g), 32'(sefi_ack), 32'(exp_ack));
      for (int k = 0; k < 9; k++) step(4'b1111, 1'b0, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0, 1'b0);
      wait_idle(4'b1111, $sformatf("fair%0d", g));
    end
    chk("fair_heal", 32'(heal_count), 32'd5);

    // Retry exhaustion on region 1.
    do_reset();
    wait_start(4'b0010, "retry");
    chk("retry_region", 32'(dpr_region), 32'd1);
    starts = 1; acks = (sefi_ack != 4'b0000) ? 1 : 0; pend = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step(4'b0000, 1'b0, pend, 1'b0);
      pend = 1'b0;
      if (dpr_start) begin starts++; pend = 1'b1; end
      if (sefi_ack != 4'b0000) acks++;
      if (!veto_pulse) break;
    end
    chk("retry_starts", 32'(starts), 32'd3);
    chk("retry_acks", 32'(acks), 32'd1);
    chk("retry_fail", 32'(region_fail), 32'b0010);
    chk("retry_heal", 32'(heal_count), 32'd0);
    chk("retry_veto_end", 32'(veto_pulse), 32'd0);
    acks = 0; starts = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0010, 1'b0, 1'b0, 1'b0);
      if (sefi_ack != 4'b0000) acks++;
      if (dpr_start) starts++;
    end
    chk("failed_region_acks", 32'(acks), 32'd0);
    chk("failed_region_starts", 32'(starts), 32'd0);
    wait_start(4'b0011, "after_fail");
    chk("after_fail_region", 32'(dpr_region), 32'd0);
    chk("after_fail_ack", 32'(sefi_ack), 32'b0001);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    wait_idle(4'b0000, "after_fail");
    chk("after_fail_sticky", 32'(region_fail), 32'b0010);

    // No engine response.
    do_reset();
    wait_start(4'b0001, "noresp");
`ifdef DPR_SCHED_WATCHDOG_EN
    starts = 1; last = 0; cyc = 0;
    for (int i = 0; i < 400; i++) begin
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      cyc++;
      if (dpr_start) begin
        starts++;
        chk($sformatf("wd_spacing%0d", starts), 32'(cyc - last), 32'd100);
        last = cyc;
      end
    end
    chk("wd_starts", 32'(starts), 32'd3);
    chk("wd_fail", 32'(region_fail), 32'b0001);
    chk("wd_veto_end", 32'(veto_pulse), 32'd0);
`else
    starts = 0; lows = 0;
    for (int i = 0; i < 10000; i++) begin
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      if (dpr_start) starts++;
      if (!veto_pulse) lows++;
    end
    chk("noresp_restarts", 32'(starts), 32'd0);
    chk("noresp_veto_lows", 32'(lows), 32'd0);
    chk("noresp_fail", 32'(region_fail), 32'd0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("noresp_late_done_heal", 32'(heal_count), 32'd1);
    wait_idle(4'b0000, "noresp");
`endif

    // Simultaneous done+error counts as an error and retries.
    do_reset();
    wait_start(4'b0100, "both");
    step(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("both_restart", 32'(dpr_start), 32'd1);
    chk("both_no_ack", 32'(sefi_ack), 32'd0);
    chk("both_region", 32'(dpr_region), 32'd2);
    chk("both_heal", 32'(heal_count), 32'd0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("both_then_done_heal", 32'(heal_count), 32'd1);
    wait_idle(4'b0000, "both");

    // Reset in the middle of RUN.
    wait_start(4'b1000, "midrst");
    chk("midrst_region", 32'(dpr_region), 32'd3);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("midrst_ack", 32'(sefi_ack), 32'd0);
    chk("midrst_start", 32'(dpr_start), 32'd0);
    chk("midrst_region0", 32'(dpr_region), 32'd0);
    chk("midrst_veto", 32'(veto_pulse), 32'd0);
    chk("midrst_fail", 32'(region_fail), 32'd0);
    chk("midrst_heal", 32'(heal_count), 32'd0);
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("postrst_start", 32'(dpr_start), 32'd1);
    chk("postrst_region", 32'(dpr_region), 32'd0);
    chk("postrst_ack", 32'(sefi_ack), 32'b0001);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    wait_idle(4'b0000, "postrst");

    // Saturation of heal_count.
    force dut.heal_count_q = 16'hFFFE;
    @(negedge clk_500mhz);
    release dut.heal_count_q;
    wait_start(4'b0001, "sat1");
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("sat_reach_max", 32'(heal_count), 32'hFFFF);
    wait_idle(4'b0000, "sat1");
    wait_start(4'b0010, "sat2");
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("sat_hold_max", 32'(heal_count), 32'hFFFF);
    wait_idle(4'b0000, "sat2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
